// File: rtl/cache_ctrl_pkg.sv
// Shared encodings for the coherent cache controller.
// Directory request, processor request, line state and FSM state.
package cache_ctrl_pkg;
   typedef enum logic [1:0] {
      CR_IDLE     = 2'd0,
      CR_BLK_RREQ = 2'd1,
      CR_BLK_EXCL = 2'd2,
      CR_OK       = 2'd3
   } creq_e;

   typedef enum logic [1:0] {
      PR_NONE  = 2'd0,
      PR_READ  = 2'd1,
      PR_WRITE = 2'd2
   } preq_e;

   typedef enum logic [1:0] {
      LS_INVALID = 2'd0,
      LS_SHARED  = 2'd1,
      LS_EXCL    = 2'd2
   } lstate_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RREQ = 3'd1,
      S_XREQ = 3'd2,
      S_WB   = 3'd3,
      S_ACK  = 3'd4
   } fsm_e;
endpackage

// File: rtl/cache_ctrl_if.sv
// Processor and directory signals of one cache controller.
// master = processor/directory side, slave = the cache.
interface cache_ctrl_if
   import cache_ctrl_pkg::*;
   #(parameter int ADDR_W = 2) ();
   preq_e             proc_req;
   logic [ADDR_W-1:0] proc_addr;
   logic              proc_wdata;
   logic              proc_ack;
   logic              proc_rdata;
   creq_e             cache_req;
   logic [ADDR_W-1:0] blk_add;
   logic              back_data;
   logic              blk_ok;
   logic              blk_data;
   logic              inval;
   logic [ADDR_W-1:0] blocknum;
   logic              write_back_req;
   logic [ADDR_W-1:0] wb_addr;

   modport master (
      output proc_req, proc_addr, proc_wdata,
      output blk_ok, blk_data, inval, blocknum,
      output write_back_req, wb_addr,
      input  proc_ack, proc_rdata, cache_req,
      input  blk_add, back_data
   );

   modport slave (
      input  proc_req, proc_addr, proc_wdata,
      input  blk_ok, blk_data, inval, blocknum,
      input  write_back_req, wb_addr,
      output proc_ack, proc_rdata, cache_req,
      output blk_add, back_data
   );
endinterface

// File: rtl/cache_line_array.sv
// Direct-mapped line store: state + 1 data bit per line.
// Priority per line: update > invalidate > bulk demote.
module cache_line_array
   import cache_ctrl_pkg::*;
   #(parameter int ADDR_W = 2) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] lk_addr_i,
   output lstate_e           lk_state_o,
   output logic              lk_data_o,
   input  logic              upd_en_i,
   input  logic [ADDR_W-1:0] upd_addr_i,
   input  lstate_e           upd_state_i,
   input  logic              upd_data_i,
   input  logic              inv_en_i,
   input  logic [ADDR_W-1:0] inv_addr_i,
   input  logic              demote_i
);
   localparam int N = 1 << ADDR_W;

   lstate_e     st_q [N];
   logic [N-1:0] dat_q;

   assign lk_state_o = st_q[lk_addr_i];
   assign lk_data_o  = dat_q[lk_addr_i];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) st_q[i] <= LS_INVALID;
         dat_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (upd_en_i && upd_addr_i == ADDR_W'(i)) begin
               st_q[i]  <= upd_state_i;
               dat_q[i] <= upd_data_i;
            end else if (inv_en_i && inv_addr_i == ADDR_W'(i)) begin
               st_q[i] <= LS_INVALID;
            end else if (demote_i && st_q[i] == LS_EXCL) begin
               st_q[i] <= LS_SHARED;
            end
         end
      end
   end
endmodule

// File: rtl/cache_ctrl.sv
// Single-bit-line coherent cache controller: processor side,
// directory requests, write-back service and invalidation.
module cache_ctrl
   import cache_ctrl_pkg::*;
   #(parameter int ADDR_W = 2) (
   input logic         clk,
   input logic         rst_n,
   cache_ctrl_if.slave bus
);
   fsm_e              state_q, resume_q;
   logic [ADDR_W-1:0] blk_add_q;
   logic              wdata_q, ack_q, rdata_q, back_q;
   creq_e             creq_q;

   lstate_e           lk_state;
   logic              lk_data;
   logic              wb_go, inv_hit, rd_req, wr_req;
   logic              rd_hit, wr_hit, fill;
   logic              upd_en, upd_data;
   logic [ADDR_W-1:0] upd_addr;
   lstate_e           upd_state;

   // The lookup port serves write-back while one is demanded.
   assign wb_go   = bus.write_back_req && state_q != S_ACK;
   assign inv_hit = bus.inval && bus.blocknum == bus.proc_addr;
   assign rd_req  = state_q == S_IDLE && bus.proc_req == PR_READ;
   assign wr_req  = state_q == S_IDLE && bus.proc_req == PR_WRITE;
   assign rd_hit  = !wb_go && rd_req && !inv_hit &&
                    lk_state != LS_INVALID;
   assign wr_hit  = !wb_go && wr_req && !inv_hit &&
                    lk_state == LS_EXCL;
   assign fill    = !wb_go && bus.blk_ok &&
                    (state_q == S_RREQ || state_q == S_XREQ);

   always_comb begin
      upd_en    = 1'b0;
      upd_addr  = blk_add_q;
      upd_state = LS_SHARED;
      upd_data  = lk_data;
      unique case (1'b1)
         wb_go: begin
            upd_en   = lk_state == LS_EXCL &&
                       !(bus.inval && bus.blocknum == bus.wb_addr);
            upd_addr = bus.wb_addr;
         end
         fill: begin
            upd_en = 1'b1;
            if (state_q == S_XREQ) begin
               upd_state = LS_EXCL;
               upd_data  = wdata_q;
            end else begin
               upd_data  = bus.blk_data;
            end
         end
         wr_hit: begin
            upd_en    = 1'b1;
            upd_addr  = bus.proc_addr;
            upd_state = LS_EXCL;
            upd_data  = bus.proc_wdata;
         end
         default: ;
      endcase
   end

   cache_line_array #(.ADDR_W(ADDR_W)) u_lines (
      .clk         (clk),
      .rst_n       (rst_n),
      .lk_addr_i   (wb_go ? bus.wb_addr : bus.proc_addr),
      .lk_state_o  (lk_state),
      .lk_data_o   (lk_data),
      .upd_en_i    (upd_en),
      .upd_addr_i  (upd_addr),
      .upd_state_i (upd_state),
      .upd_data_i  (upd_data),
      .inv_en_i    (bus.inval),
      .inv_addr_i  (bus.blocknum),
      .demote_i    (fill && state_q == S_RREQ)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         resume_q  <= S_IDLE;
         blk_add_q <= '0;
         wdata_q   <= 1'b0;
         ack_q     <= 1'b0;
         rdata_q   <= 1'b0;
         creq_q    <= CR_IDLE;
         back_q    <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         if (wb_go) begin
            if (state_q != S_WB) resume_q <= state_q;
            state_q <= S_WB;
            creq_q  <= CR_OK;
            back_q  <= lk_data;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (rd_hit || wr_hit) begin
                     state_q <= S_ACK;
                     ack_q   <= 1'b1;
                     if (rd_hit) rdata_q <= lk_data;
                  end else if (rd_req) begin
                     state_q   <= S_RREQ;
                     creq_q    <= CR_BLK_RREQ;
                     blk_add_q <= bus.proc_addr;
                  end else if (wr_req) begin
                     state_q   <= S_XREQ;
                     creq_q    <= CR_BLK_EXCL;
                     blk_add_q <= bus.proc_addr;
                     wdata_q   <= bus.proc_wdata;
                  end
               end
               S_RREQ, S_XREQ: begin
                  if (bus.blk_ok) begin
                     state_q <= S_ACK;
                     ack_q   <= 1'b1;
                     creq_q  <= CR_IDLE;
                     if (state_q == S_RREQ) rdata_q <= bus.blk_data;
                  end
               end
               S_WB: begin
                  state_q <= resume_q;
                  back_q  <= 1'b0;
                  unique case (resume_q)
                     S_RREQ:  creq_q <= CR_BLK_RREQ;
                     S_XREQ:  creq_q <= CR_BLK_EXCL;
                     default: creq_q <= CR_IDLE;
                  endcase
               end
               S_ACK:   state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.proc_ack   = ack_q;
   assign bus.proc_rdata = rdata_q;
   assign bus.cache_req  = creq_q;
   assign bus.blk_add    = blk_add_q;
   assign bus.back_data  = back_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl: line-state model plus
// a read-data scoreboard drained by an ack monitor.
module tb_cache_ctrl;
   import cache_ctrl_pkg::*;

   localparam int AW = 2;
   localparam int NL = 4;

   typedef struct {
      bit is_rd;
      bit rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_ctrl_if #(.ADDR_W(AW)) bus ();

   cache_ctrl #(.ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   // 0 = invalid, 1 = shared, 2 = exclusive
   int   mst[NL];
   bit   md[NL];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.proc_ack === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack=1 expected none");
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_rd)
               chk("rdata", int'(bus.proc_rdata), int'(mon_e.rdata));
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < NL; i++) begin
         mst[i] = 0;
         md[i]  = 1'b0;
      end
   endtask

   task automatic req_txn(input preq_e kind, input int a,
                          input bit wd, input bit bd,
                          input bit wbm, input int wba,
                          input bit inv_same);
      bit    hit;
      creq_e ec;
      exp_t  e;
      @(negedge clk);
      if (inv_same) begin
         bus.inval    = 1'b1;
         bus.blocknum = AW'(a);
         mst[a]       = 0;
      end
      hit = (kind == PR_READ) ? (mst[a] != 0) : (mst[a] == 2);
      ec  = (kind == PR_READ) ? CR_BLK_RREQ : CR_BLK_EXCL;
      bus.proc_req   = kind;
      bus.proc_addr  = AW'(a);
      bus.proc_wdata = wd;
      e.is_rd = (kind == PR_READ);
      e.rdata = hit ? md[a] : bd;
      sb.push_back(e);
      @(negedge clk);
      bus.inval = 1'b0;
      if (hit) begin
         chk("hit_creq", int'(bus.cache_req), int'(CR_IDLE));
         if (kind == PR_WRITE) md[a] = wd;
      end else begin
         chk("miss_creq", int'(bus.cache_req), int'(ec));
         chk("miss_addr", int'(bus.blk_add), a);
         if (wbm) begin
            bus.write_back_req = 1'b1;
            bus.wb_addr        = AW'(wba);
            repeat (2) begin
               @(negedge clk);
               chk("wb_creq", int'(bus.cache_req), int'(CR_OK));
               chk("wb_data", int'(bus.back_data), int'(md[wba]));
            end
            if (mst[wba] == 2) mst[wba] = 1;
            bus.write_back_req = 1'b0;
            @(negedge clk);
            chk("resume_creq", int'(bus.cache_req), int'(ec));
            chk("resume_addr", int'(bus.blk_add), a);
         end
         bus.blk_ok   = 1'b1;
         bus.blk_data = bd;
         @(negedge clk);
         bus.blk_ok = 1'b0;
         if (kind == PR_READ) begin
            for (int i = 0; i < NL; i++) if (mst[i] == 2) mst[i] = 1;
            mst[a] = 1;
            md[a]  = bd;
         end else begin
            mst[a] = 2;
            md[a]  = wd;
         end
      end
      chk("ack", int'(bus.proc_ack), 1);
      bus.proc_req = PR_NONE;
   endtask

   task automatic wb_txn(input int a, input int n);
      @(negedge clk);
      bus.write_back_req = 1'b1;
      bus.wb_addr        = AW'(a);
      repeat (n) begin
         @(negedge clk);
         chk("wbs_creq", int'(bus.cache_req), int'(CR_OK));
         chk("wbs_data", int'(bus.back_data), int'(md[a]));
      end
      if (mst[a] == 2) mst[a] = 1;
      bus.write_back_req = 1'b0;
      @(negedge clk);
      chk("wbs_idle", int'(bus.cache_req), int'(CR_IDLE));
   endtask

   task automatic inv_txn(input int a);
      @(negedge clk);
      bus.inval    = 1'b1;
      bus.blocknum = AW'(a);
      @(negedge clk);
      bus.inval = 1'b0;
      mst[a]    = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int op, a, kind;
      bus.proc_req       = PR_NONE;
      bus.proc_addr      = '0;
      bus.proc_wdata     = 1'b0;
      bus.blk_ok         = 1'b0;
      bus.blk_data       = 1'b0;
      bus.inval          = 1'b0;
      bus.blocknum       = '0;
      bus.write_back_req = 1'b0;
      bus.wb_addr        = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_ack", int'(bus.proc_ack), 0);
      chk("rst_rdata", int'(bus.proc_rdata), 0);
      chk("rst_creq", int'(bus.cache_req), int'(CR_IDLE));
      chk("rst_blk_add", int'(bus.blk_add), 0);
      chk("rst_back", int'(bus.back_data), 0);
      rst_n = 1'b1;

      // read fill then hit
      req_txn(PR_READ, 2, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      req_txn(PR_READ, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      // write miss, write hit, read hit
      req_txn(PR_WRITE, 1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      req_txn(PR_WRITE, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      req_txn(PR_READ, 1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      // write-back demotes an exclusive line
      req_txn(PR_WRITE, 1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      wb_txn(1, 1);
      req_txn(PR_WRITE, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      // write-back interrupting a pending read
      req_txn(PR_READ, 3, 1'b0, 1'b1, 1'b1, 1, 1'b0);
      // same-cycle invalidate forces a miss
      req_txn(PR_READ, 2, 1'b0, 1'b0, 1'b0, 0, 1'b1);

      // reset while an exclusive request is pending
      @(negedge clk);
      bus.proc_req   = PR_WRITE;
      bus.proc_addr  = AW'(0);
      bus.proc_wdata = 1'b1;
      @(negedge clk);
      chk("xreq_pre_rst", int'(bus.cache_req), int'(CR_BLK_EXCL));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_creq", int'(bus.cache_req), int'(CR_IDLE));
      chk("rst_mid_ack", int'(bus.proc_ack), 0);
      bus.proc_req = PR_NONE;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      req_txn(PR_READ, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

      for (int it = 0; it < 200; it++) begin
         op   = int'($urandom_range(0, 9));
         a    = int'($urandom_range(0, NL - 1));
         kind = int'($urandom_range(0, 1));
         if (op < 7)
            req_txn(kind != 0 ? PR_WRITE : PR_READ, a,
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, NL - 1)),
                    ($urandom_range(0, 7) == 0));
         else if (op < 9)
            wb_txn(a, int'($urandom_range(1, 3)));
         else
            inv_txn(a);
      end

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
